// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the sequential divider and anything that unpacks its
// result bus (ALU result mux, writeback, bench):
//   - state_e  : FSM state encodings (IDLE=0, BUSY=1, DONE=2)
//   - QUOT_LSB : bit offset of the quotient field in the packed result
//   - rem_lsb(): bit offset of the remainder field for a given operand width
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result bus layout: {remainder, quotient}, each one operand wide.
  localparam int unsigned QUOT_LSB = 0;

  function automatic int unsigned rem_lsb(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, then subtract the divisor if it fits and record
// a 1 in the quotient LSB.
// Ports:
//   r_i [p_width:0]    partial remainder in
//   q_i [p_width-1:0]  shifting dividend/quotient register in
//   d_i [p_width-1:0]  divisor
//   r_o [p_width:0]    partial remainder out
//   q_o [p_width-1:0]  quotient register out
// -----------------------------------------------------------------------------
module div_step #(
  parameter int p_width = 4
) (
  input  logic [p_width:0]   r_i,
  input  logic [p_width-1:0] q_i,
  input  logic [p_width-1:0] d_i,
  output logic [p_width:0]   r_o,
  output logic [p_width-1:0] q_o
);

  logic [p_width:0] r_sh;
  logic             fits;

  always_comb begin
    r_sh = {r_i[p_width-1:0], q_i[p_width-1]};
    // A set top bit means the shifted value exceeds any p_width-bit divisor.
    fits = r_i[p_width] | (r_sh >= {1'b0, d_i});
    r_o  = r_sh;
    q_o  = {q_i[p_width-2:0], fits};
    if (fits) begin
      r_o = r_sh - {1'b0, d_i};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Operands accepted via valid/ready in IDLE, p_width BUSY steps, then the
// result {remainder, quotient} is held in DONE until the consumer accepts it.
// Ports:
//   i_w_clk, i_w_reset        clock, synchronous active-high reset
//   i_w_a, i_w_b              dividend, divisor (sampled on handshake)
//   i_w_valid / o_w_ready     operand handshake (ready only in IDLE)
//   o_w_out                   {remainder, quotient}
//   o_w_valid / i_w_ready     result handshake
//   o_w_div0                  divisor was zero
// Build option: define SEQ_DIVIDER_DIV0_SHORTCUT_EN to skip the BUSY phase
// for a zero divisor (same result values, available one edge after accept).
// -----------------------------------------------------------------------------
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int p_width = 4
) (
  input  logic                   i_w_clk,
  input  logic                   i_w_reset,
  input  logic [p_width-1:0]     i_w_a,
  input  logic [p_width-1:0]     i_w_b,
  input  logic                   i_w_valid,
  output logic                   o_w_ready,
  output logic [2*p_width-1:0]   o_w_out,
  output logic                   o_w_valid,
  input  logic                   i_w_ready,
  output logic                   o_w_div0
);

  localparam int CNT_W   = $clog2(p_width + 1);
  localparam int REM_LSB = rem_lsb(p_width);

  state_e               state_q;
  logic [p_width:0]     r_q;
  logic [p_width-1:0]   q_q;
  logic [p_width-1:0]   d_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 div0_q;
  logic [2*p_width-1:0] out_q;
  logic                 valid_q;
  logic                 ready_q;

  logic [p_width:0]     r_d;
  logic [p_width-1:0]   q_d;

  div_step #(.p_width(p_width)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      div0_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_w_valid && ready_q) begin
            q_q     <= i_w_a;
            d_q     <= i_w_b;
            r_q     <= '0;
            cnt_q   <= '0;
            div0_q  <= (i_w_b == '0);
            ready_q <= 1'b0;
`ifdef SEQ_DIVIDER_DIV0_SHORTCUT_EN
            if (i_w_b == '0) begin
              // Same values a full run would produce, just without iterating.
              out_q[REM_LSB +: p_width]  <= i_w_a;
              out_q[QUOT_LSB +: p_width] <= '1;
              valid_q                    <= 1'b1;
              state_q                    <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
`else
            state_q <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(p_width - 1)) begin
            // Last step: publish the step outputs directly so valid and data
            // rise together.
            out_q[REM_LSB +: p_width]  <= r_d[p_width-1:0];
            out_q[QUOT_LSB +: p_width] <= q_d;
            valid_q                    <= 1'b1;
            state_q                    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_w_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_w_ready = ready_q;
  assign o_w_out   = out_q;
  assign o_w_valid = valid_q;
  assign o_w_div0  = div0_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           i_w_reset;
  logic [W-1:0]   i_w_a;
  logic [W-1:0]   i_w_b;
  logic           i_w_valid;
  logic           o_w_ready;
  logic [2*W-1:0] o_w_out;
  logic           o_w_valid;
  logic           i_w_ready;
  logic           o_w_div0;

  int total = 0;
  int bad   = 0;

  // Each entry: {div0, remainder, quotient}
  logic [2*W:0] sb[$];

  seq_divider #(.p_width(W)) dut (
    .i_w_clk   (clk),
    .i_w_reset (i_w_reset),
    .i_w_a     (i_w_a),
    .i_w_b     (i_w_b),
    .i_w_valid (i_w_valid),
    .o_w_ready (o_w_ready),
    .o_w_out   (o_w_out),
    .o_w_valid (o_w_valid),
    .i_w_ready (i_w_ready),
    .o_w_div0  (o_w_div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient
  // and the dividend as remainder.
  function automatic logic [2*W:0] model(input int a, input int b);
    int q;
    int r;
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {(b == 0), W'(r), W'(q)};
  endfunction

  // Monitor: compares every result the consumer actually takes.
  initial begin
    logic [2*W:0] e;
    forever begin
      @(negedge clk);
      if (!i_w_reset && o_w_valid && i_w_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %0h expected none", o_w_out);
        end else begin
          e = sb.pop_front();
          $display("txn out=%02h div0=%0b exp_out=%02h exp_div0=%0b",
                   o_w_out, o_w_div0, e[2*W-1:0], e[2*W]);
          check("result_out", 32'(o_w_out), 32'(e[2*W-1:0]));
          check("result_div0", 32'(o_w_div0), 32'(e[2*W]));
        end
      end
    end
  end

  task automatic wait_drain();
    int g = 0;
    while (o_w_valid && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drained", 32'(o_w_valid), 32'd0);
    check("ready_after_drain", 32'(o_w_ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W:0] exp, input bit hold);
    int lat;
    int exp_lat;
    int g = 0;
    i_w_a     = a;
    i_w_b     = b;
    i_w_valid = 1'b1;
    while (!o_w_ready && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    @(posedge clk);
    sb.push_back(exp);
    #1;
    i_w_valid = 1'b0;
    i_w_a     = W'($urandom);
    i_w_b     = W'($urandom);
    lat = 1;
    while (!o_w_valid && lat < 40) begin
      check("ready_low_busy", 32'(o_w_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = W + 1;
`ifdef SEQ_DIVIDER_DIV0_SHORTCUT_EN
    if (b == '0) exp_lat = 1;
`endif
    check("latency", 32'(lat), 32'(exp_lat));
    check("ready_low_done", 32'(o_w_ready), 32'd0);
    if (!hold) wait_drain();
  endtask

  initial begin
    int a;
    int b;
    int g;
    i_w_reset = 1'b1;
    i_w_a     = '0;
    i_w_b     = '0;
    i_w_valid = 1'b0;
    i_w_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_w_reset = 1'b0;
    check("reset_out", 32'(o_w_out), 32'd0);
    check("reset_valid", 32'(o_w_valid), 32'd0);
    check("reset_div0", 32'(o_w_div0), 32'd0);
    check("reset_ready", 32'(o_w_ready), 32'd1);

    // Directed cases
    run_op(4'd13, 4'd3, 9'h014, 1'b0);
    run_op(4'd2,  4'd5, 9'h020, 1'b0);
    run_op(4'd15, 4'd1, 9'h00F, 1'b0);
    run_op(4'd0,  4'd7, 9'h000, 1'b0);
    run_op(4'd7,  4'd0, 9'h17F, 1'b0);

    // Back-pressure: result must hold while the consumer stalls, and new
    // operands offered meanwhile must be ignored.
    i_w_ready = 1'b0;
    run_op(4'd13, 4'd3, 9'h014, 1'b1);
    for (int i = 0; i < 10; i++) begin
      i_w_a     = 4'd1;
      i_w_b     = 4'd1;
      i_w_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid", 32'(o_w_valid), 32'd1);
      check("bp_out", 32'(o_w_out), 32'h14);
      check("bp_ready", 32'(o_w_ready), 32'd0);
    end
    i_w_valid = 1'b0;
    i_w_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(o_w_valid), 32'd0);
    check("bp_release_ready", 32'(o_w_ready), 32'd1);

    // Reset during the second BUSY cycle aborts the division.
    i_w_a     = 4'd13;
    i_w_b     = 4'd3;
    i_w_valid = 1'b1;
    @(posedge clk);
    #1;
    i_w_valid = 1'b0;
    @(posedge clk);
    #1;
    i_w_reset = 1'b1;
    @(posedge clk);
    #1;
    i_w_reset = 1'b0;
    check("abort_valid", 32'(o_w_valid), 32'd0);
    check("abort_ready", 32'(o_w_ready), 32'd1);
    check("abort_out", 32'(o_w_out), 32'd0);
    run_op(4'd9, 4'd2, 9'h014, 1'b0);

    // Back-to-back random operations with a non-zero divisor
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(1, (1 << W) - 1));
      run_op(W'(a), W'(b), model(a, b), 1'b0);
    end
    // A few more with any divisor, zero included
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = (i == 2) ? 0 : int'($urandom_range(0, (1 << W) - 1));
      run_op(W'(a), W'(b), model(a, b), 1'b0);
    end

    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
